// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: shared types, constants and nibble helpers
// for the seven-segment scan scheduler.
package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [3:0] AN_PATTERN [0:NUM_DIGITS-1] = '{
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    function automatic logic [DIGIT_W-1:0] nibble(
        input logic [15:0] w,
        input logic [1:0]  i
    );
        return w[{i, 2'b00} +: DIGIT_W];
    endfunction

    // Digit i is a leading zero when nibbles i..3 are all zero;
    // digit 0 is never blanked.
    function automatic logic lead_zero(
        input logic [15:0] w,
        input logic [1:0]  i
    );
        return (i != 2'd0) && ((w >> {i, 2'b00}) == 16'h0000);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: valid/ready request bundle for the two
// display requesters (A and B).
interface display_scan_ctrl_if;

    logic        req_a_valid;
    logic [15:0] req_a_data;
    logic        req_a_ready;
    logic        req_b_valid;
    logic [15:0] req_b_data;
    logic        req_b_ready;

    modport master (
        output req_a_valid, req_a_data,
        input  req_a_ready,
        output req_b_valid, req_b_data,
        input  req_b_ready
    );

    modport slave (
        input  req_a_valid, req_a_data,
        output req_a_ready,
        input  req_b_valid, req_b_data,
        output req_b_ready
    );

endinterface

// File: rtl/display_scan_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; grants only while
// enable is high, remembers the last source granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last_grant_b;

    // Pick a winner; on a tie, favour the source not served last.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_b ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Record the winner; reset to B so A wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant_b <= 1'b1;
        else if (|grant)
            last_grant_b <= grant[1];
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit seven-segment scan scheduler with
// two arbitrated requesters. Define LZB_EN for leading-zero blanking.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                reset_n,
    display_scan_ctrl_if.slave  req,
    output logic                src_b,
    output logic [3:0]          digit_val,
    output logic [3:0]          an,
    output logic                frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    logic [CW-1:0] cnt;
    scan_state_t   state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [15:0]   shadow;
    logic [1:0]    grant;
    logic [3:0]    an_nx;

    // Slot counter: 0..PRESCALE-1, then wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // State and digit index registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
            idx   <= 2'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next state; frame ends as digit 3 leaves SHOW.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        frame_done = 1'b0;
        unique case (state)
            BLANK: begin
                if (cnt == BLANK_LAST)
                    state_nx = SHOW;
            end
            SHOW: begin
                if (cnt == CNT_LAST) begin
                    state_nx   = BLANK;
                    idx_nx     = idx + 2'd1;
                    frame_done = (idx == 2'd3);
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req.req_b_valid, req.req_a_valid}),
        .enable  (frame_done),
        .grant   (grant)
    );

    assign req.req_a_ready = grant[0];
    assign req.req_b_ready = grant[1];

    // Shadow word only changes at a frame boundary transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= 16'h0000;
            src_b  <= 1'b0;
        end else if (|grant) begin
            shadow <= grant[1] ? req.req_b_data : req.req_a_data;
            src_b  <= grant[1];
        end
    end

    // Anode pattern for the current slot.
    always_comb begin
        an_nx = AN_OFF;
        if (state == SHOW) begin
            an_nx = AN_PATTERN[idx];
`ifdef LZB_EN
            if (lead_zero(shadow, idx))
                an_nx = AN_OFF;
`else
`endif
        end
    end

    // Registered display outputs; digit_val holds through BLANK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an        <= AN_OFF;
            digit_val <= 4'h0;
        end else begin
            an <= an_nx;
            if (state == SHOW)
                digit_val <= nibble(shadow, idx);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed + random stimulus against a
// cycle-count reference model of the scan scheduler.
module tb_display_scan_ctrl;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = 4 * PRESCALE;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       src_b;
    logic [3:0] digit_val;
    logic [3:0] an;
    logic       frame_done;

    display_scan_ctrl_if rif ();

    display_scan_ctrl #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (rif),
        .src_b      (src_b),
        .digit_val  (digit_val),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    int          t;
    logic [15:0] m_shadow;
    logic        m_src;
    logic        m_lastb;
    logic [3:0]  m_an;
    logic [3:0]  m_dv;

    logic        pend_a, pend_b;
    logic        sticky_a, sticky_b;
    logic [15:0] da, db;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s t=%0d: got %h want %h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_shadow = 16'h0000;
        m_src    = 1'b0;
        m_lastb  = 1'b1;
        m_an     = 4'hF;
        m_dv     = 4'h0;
    endtask

    function automatic logic [3:0] lit_pattern(input int dg,
                                               input logic [15:0] sh);
        logic [3:0]  p;
        logic [3:0]  one_hot;
        one_hot = 4'b1000 >> dg;
        p = 4'hF ^ one_hot;
`ifdef LZB_EN
        if (dg >= 1 && (sh >> (4 * dg)) == 16'h0000)
            p = 4'hF;
`else
        if (sh === 16'hxxxx)
            p = 4'hF;
`endif
        return p;
    endfunction

    // One clock cycle: drive, check this cycle, advance model.
    task automatic cycle();
        int   ph, dg;
        logic fd, ga, gb;
        logic [15:0] sh_word;
        rif.req_a_valid = pend_a;
        rif.req_a_data  = da;
        rif.req_b_valid = pend_b;
        rif.req_b_data  = db;
        #1;
        ph = t % PRESCALE;
        dg = (t / PRESCALE) % 4;
        fd = ((t % FRAME) == FRAME - 1);
        ga = 1'b0;
        gb = 1'b0;
        if (fd) begin
            if (pend_a && pend_b) begin
                ga = m_lastb;
                gb = !m_lastb;
            end else begin
                ga = pend_a;
                gb = pend_b;
            end
        end
        check("an",         {12'h0, an},          {12'h0, m_an});
        check("digit_val",  {12'h0, digit_val},   {12'h0, m_dv});
        check("frame_done", {15'h0, frame_done},  {15'h0, fd});
        check("ready_a",    {15'h0, rif.req_a_ready}, {15'h0, ga});
        check("ready_b",    {15'h0, rif.req_b_ready}, {15'h0, gb});
        check("src_b",      {15'h0, src_b},       {15'h0, m_src});
        if (ph >= BLANK) begin
            m_an    = lit_pattern(dg, m_shadow);
            sh_word = (m_shadow >> (4 * dg)) & 16'h000F;
            m_dv    = sh_word[3:0];
        end else begin
            m_an = 4'hF;
        end
        if (ga) begin
            m_shadow = da;
            m_src    = 1'b0;
            m_lastb  = 1'b0;
            pend_a   = 1'b0;
        end
        if (gb) begin
            m_shadow = db;
            m_src    = 1'b1;
            m_lastb  = 1'b1;
            pend_b   = 1'b0;
        end
        if (sticky_a) pend_a = 1'b1;
        if (sticky_b) pend_b = 1'b1;
        t++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic run_to(input int ph);
        for (int k = 0; k < FRAME && (t % FRAME) != ph; k++) cycle();
    endtask

    // Hold reset, check reset values, release on a negedge.
    task automatic apply_reset();
        reset_n  = 1'b0;
        pend_a   = 1'b0;
        pend_b   = 1'b0;
        sticky_a = 1'b0;
        sticky_b = 1'b0;
        rif.req_a_valid = 1'b0;
        rif.req_b_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_an",      {12'h0, an},        16'h000F);
        check("rst_dv",      {12'h0, digit_val}, 16'h0000);
        check("rst_fd",      {15'h0, frame_done}, 16'h0000);
        check("rst_ready_a", {15'h0, rif.req_a_ready}, 16'h0000);
        check("rst_ready_b", {15'h0, rif.req_b_ready}, 16'h0000);
        check("rst_src_b",   {15'h0, src_b},     16'h0000);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        pend_a = 1'b0; pend_b = 1'b0;
        sticky_a = 1'b0; sticky_b = 1'b0;
        da = 16'h0000; db = 16'h0000;
        rif.req_a_valid = 1'b0;
        rif.req_a_data  = 16'h0000;
        rif.req_b_valid = 1'b0;
        rif.req_b_data  = 16'h0000;
        model_reset();

        // Idle scan after reset.
        apply_reset();
        run(FRAME + 5);

        // A word arrives mid-frame.
        run_to(12);
        pend_a = 1'b1;
        da = 16'h4321;
        run(2 * FRAME);

        // Both held valid: round-robin from a fresh reset.
        apply_reset();
        da = 16'h1111;
        db = 16'h2222;
        pend_a = 1'b1; pend_b = 1'b1;
        sticky_a = 1'b1; sticky_b = 1'b1;
        run(4 * FRAME + 4);
        sticky_a = 1'b0; sticky_b = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0;
        run_to(0);

        // B drops before the boundary.
        run_to(5);
        pend_b = 1'b1;
        db = 16'h9ABC;
        run(10);
        pend_b = 1'b0;
        run(2 * FRAME);

        // Reset during digit 2 SHOW with A pending.
        pend_a = 1'b1;
        da = 16'hBEEF;
        run_to(20);
        rif.req_a_valid = pend_a;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_an", {12'h0, an},        16'h000F);
        check("async_dv", {12'h0, digit_val}, 16'h0000);
        check("async_ra", {15'h0, rif.req_a_ready}, 16'h0000);
        @(negedge clk);
        apply_reset();
        run(FRAME + 3);

        // Leading zeros: 0050.
        run_to(4);
        pend_a = 1'b1;
        da = 16'h0050;
        run(2 * FRAME);

        // Random requesters with random drops.
        for (int k = 0; k < 20 * FRAME; k++) begin
            if (!pend_a && $urandom_range(0, 15) == 0) begin
                pend_a = 1'b1;
                da = 16'($urandom);
            end else if (pend_a && $urandom_range(0, 63) == 0) begin
                pend_a = 1'b0;
            end
            if (!pend_b && $urandom_range(0, 15) == 0) begin
                pend_b = 1'b1;
                db = 16'($urandom);
            end else if (pend_b && $urandom_range(0, 63) == 0) begin
                pend_b = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
